// File: rtl/arm_pkg.sv
// Shared encodings for the ARM core pipeline control: operand forwarding
// sources and the memory-wait FSM states.
package arm_pkg;
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } mem_state_e;
endpackage

// File: rtl/pipe_ctrl_unit_fwd_select.sv
// Forwarding-source comparator for one EXE operand; MEM result is younger
// than WB, so it wins when both match.
module fwd_select
    import arm_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              wb_en,
    output logic [1:0]        sel
);
    always_comb begin
        sel = FWD_RF;
        if (wb_en && (src == wb_dest))
            sel = FWD_WB;
        if (mem_wb_en && (src == mem_dest))
            sel = FWD_MEM;
    end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the 5-stage ARM core: hazard stall, branch-shadow
// flush, memory-wait freeze, operand forwarding and a stall counter.
module pipe_ctrl_unit
    import arm_pkg::*;
#(
    parameter int REG_AW          = 4,
    parameter int FWD_EN          = 1,
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [REG_AW-1:0] exe_src1,
    input  logic [REG_AW-1:0] exe_src2,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              wb_en,
    input  logic              branch_taken,
    output logic              freeze_front,
    output logic              bubble_id_exe,
    output logic              freeze_all,
    output logic              flush_if_id,
    output logic              flush_id_exe,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              mem_wait,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [1:0] BR_LOAD = 2'(BR_FLUSH_CYCLES - 1);

    mem_state_e state;
    logic [1:0] flush_cnt;

    logic exe_hit, mem_hit, hazard;
    logic freeze_all_i, br_flush_i, flush_if_id_i, stall_i;
    logic [1:0][REG_AW-1:0] exe_src;
    logic [1:0][1:0]        fwd_sel;

    // A second source only counts when the ID instruction actually reads it.
    assign exe_hit = exe_wb_en && ((id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest)));
    assign mem_hit = mem_wb_en && ((id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest)));
    assign hazard  = id_valid && ((FWD_EN != 0) ? (exe_mem_r_en && exe_hit) : (exe_hit || mem_hit));

    assign exe_src = {exe_src2, exe_src1};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        fwd_select #(.REG_AW(REG_AW)) u_fwd (
            .src       (exe_src[g]),
            .mem_dest  (mem_dest),
            .mem_wb_en (mem_wb_en),
            .wb_dest   (wb_dest),
            .wb_en     (wb_en),
            .sel       (fwd_sel[g])
        );
    end

    // Priority: memory freeze, then branch flush, then hazard stall.
    assign freeze_all_i  = mem_req && !mem_ready;
    assign br_flush_i    = branch_taken && !freeze_all_i;
    assign flush_if_id_i = br_flush_i || ((flush_cnt != 2'd0) && !freeze_all_i);
    assign stall_i       = hazard && !freeze_all_i && !flush_if_id_i;

    assign freeze_front  = stall_i && !rst;
    assign bubble_id_exe = stall_i && !rst;
    assign freeze_all    = freeze_all_i && !rst;
    assign flush_if_id   = flush_if_id_i && !rst;
    assign flush_id_exe  = br_flush_i && !rst;
    assign fwd_sel_a     = (rst || FWD_EN == 0) ? FWD_RF : fwd_sel[0];
    assign fwd_sel_b     = (rst || FWD_EN == 0) ? FWD_RF : fwd_sel[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mem_wait <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (mem_req && !mem_ready) begin
                    state    <= ST_MEM_WAIT;
                    mem_wait <= 1'b1;
                end
                ST_MEM_WAIT: if (mem_ready) begin
                    state    <= ST_IDLE;
                    mem_wait <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    mem_wait <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flush_cnt <= 2'd0;
        else if (freeze_all_i)
            flush_cnt <= flush_cnt;
        else if (branch_taken)
            flush_cnt <= BR_LOAD;
        else if (flush_cnt != 2'd0)
            flush_cnt <= flush_cnt - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if ((stall_i || freeze_all_i) && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench: dut0 is forwarding mode with a 3-cycle branch shadow,
// dut1 is stall-on-RAW with a 1-cycle shadow and a 2-bit stall counter.
module tb_pipe_ctrl_unit;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] id_src1, id_src2, exe_dest, exe_src1, exe_src2, mem_dest, wb_dest;
    logic id_two_src, id_valid, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic mem_req, mem_ready, wb_en, branch_taken;

    logic ff0, bub0, fa0, fif0, fie0, mw0;
    logic [1:0] fa_a0, fa_b0;
    logic [15:0] sc0;
    logic ff1, bub1, fa1, fif1, fie1, mw1;
    logic [1:0] fa_a1, fa_b1;
    logic [1:0] sc1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_AW(4), .FWD_EN(1), .BR_FLUSH_CYCLES(3), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_valid(id_valid), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .mem_ready(mem_ready), .wb_dest(wb_dest), .wb_en(wb_en),
        .branch_taken(branch_taken), .freeze_front(ff0), .bubble_id_exe(bub0), .freeze_all(fa0),
        .flush_if_id(fif0), .flush_id_exe(fie0), .fwd_sel_a(fa_a0), .fwd_sel_b(fa_b0),
        .mem_wait(mw0), .stall_cnt(sc0));

    pipe_ctrl_unit #(.REG_AW(4), .FWD_EN(0), .BR_FLUSH_CYCLES(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_valid(id_valid), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .mem_req(mem_req), .mem_ready(mem_ready), .wb_dest(wb_dest), .wb_en(wb_en),
        .branch_taken(branch_taken), .freeze_front(ff1), .bubble_id_exe(bub1), .freeze_all(fa1),
        .flush_if_id(fif1), .flush_id_exe(fie1), .fwd_sel_a(fa_a1), .fwd_sel_b(fa_b1),
        .mem_wait(mw1), .stall_cnt(sc1));

    task automatic clear_inputs();
        id_src1 = 0; id_src2 = 0; exe_dest = 0; exe_src1 = 0; exe_src2 = 0;
        mem_dest = 0; wb_dest = 0; id_two_src = 0; id_valid = 0; exe_wb_en = 0;
        exe_mem_r_en = 0; mem_wb_en = 0; mem_req = 0; mem_ready = 0; wb_en = 0;
        branch_taken = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        // provoke every output, then confirm reset masks them all
        rst = 1'b1;
        id_valid = 1; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 3; id_src1 = 3;
        exe_src1 = 5; exe_src2 = 5; mem_dest = 5; mem_wb_en = 1;
        mem_req = 1; mem_ready = 0; branch_taken = 1;
        step();
        if ({ff0, bub0, fa0, fif0, fie0, fa_a0, fa_b0, mw0} !== 11'd0) begin
            $display("FAIL reset_outputs: got %b exp 0", {ff0, bub0, fa0, fif0, fie0, fa_a0, fa_b0, mw0});
            n_errors++;
        end
        n_checks++;
        if (sc0 !== 16'd0) begin
            $display("FAIL reset_stall_cnt: got %0d exp 0", sc0);
            n_errors++;
        end
        n_checks++;
        rst = 1'b0;
        clear_inputs();
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3; id_src1 = 3; id_valid = 1;
        #1;
        if ({ff0, bub0} !== 2'b11) begin
            $display("FAIL load_use_stall: got %b exp 11", {ff0, bub0});
            n_errors++;
        end
        n_checks++;
        if (sc0 !== 16'd0) begin
            $display("FAIL load_use_cnt_before: got %0d exp 0", sc0);
            n_errors++;
        end
        n_checks++;
        step();
        if (sc0 !== 16'd1) begin
            $display("FAIL load_use_cnt_after: got %0d exp 1", sc0);
            n_errors++;
        end
        n_checks++;
        id_valid = 0;
        #1;
        if ({ff0, bub0} !== 2'b00) begin
            $display("FAIL load_use_bubble_id: got %b exp 00", {ff0, bub0});
            n_errors++;
        end
        n_checks++;
        id_valid = 1; exe_mem_r_en = 0;
        #1;
        if (ff0 !== 1'b0) begin
            $display("FAIL fwd_mode_no_load: got %b exp 0", ff0);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_forwarding();
        do_reset();
        exe_src1 = 5; mem_dest = 5; mem_wb_en = 1; wb_dest = 5; wb_en = 1; exe_src2 = 9;
        #1;
        if (fa_a0 !== 2'b01) begin
            $display("FAIL fwd_mem_priority: got %b exp 01", fa_a0);
            n_errors++;
        end
        n_checks++;
        if (fa_b0 !== 2'b00) begin
            $display("FAIL fwd_b_none: got %b exp 00", fa_b0);
            n_errors++;
        end
        n_checks++;
        if ({fa_a1, fa_b1} !== 4'b0000) begin
            $display("FAIL fwd_disabled: got %b exp 0000", {fa_a1, fa_b1});
            n_errors++;
        end
        n_checks++;
        mem_wb_en = 0; exe_src2 = 5;
        #1;
        if ({fa_a0, fa_b0} !== 4'b1010) begin
            $display("FAIL fwd_wb: got %b exp 1010", {fa_a0, fa_b0});
            n_errors++;
        end
        n_checks++;
        wb_en = 0; mem_wb_en = 1; mem_dest = 9; exe_src2 = 9;
        #1;
        if ({fa_a0, fa_b0} !== 4'b0001) begin
            $display("FAIL fwd_b_mem: got %b exp 0001", {fa_a0, fa_b0});
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_raw_stall();
        do_reset();
        id_src2 = 7; id_two_src = 1; mem_dest = 7; mem_wb_en = 1; id_valid = 1; id_src1 = 2;
        #1;
        if ({ff1, bub1} !== 2'b11) begin
            $display("FAIL raw_src2_stall: got %b exp 11", {ff1, bub1});
            n_errors++;
        end
        n_checks++;
        if (ff0 !== 1'b0) begin
            $display("FAIL raw_fwd_mode_no_stall: got %b exp 0", ff0);
            n_errors++;
        end
        n_checks++;
        id_two_src = 0;
        #1;
        if ({ff1, bub1} !== 2'b00) begin
            $display("FAIL raw_one_src: got %b exp 00", {ff1, bub1});
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_branch_flush();
        logic [2:0] exp_fif0;
        exp_fif0 = 3'b111;
        do_reset();
        exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3; id_src1 = 3; id_valid = 1;
        branch_taken = 1;
        #1;
        if ({fif0, fie0, ff0, bub0} !== 4'b1100) begin
            $display("FAIL branch_first: got %b exp 1100", {fif0, fie0, ff0, bub0});
            n_errors++;
        end
        n_checks++;
        for (int i = 1; i < 3; i++) begin
            step();
            branch_taken = 0;
            #1;
            if ({fif0, fie0, ff0} !== {exp_fif0[i], 2'b00}) begin
                $display("FAIL branch_shadow_%0d: got %b exp %b", i, {fif0, fie0, ff0}, {exp_fif0[i], 2'b00});
                n_errors++;
            end
            n_checks++;
            if (i == 1 && fif1 !== 1'b0) begin
                $display("FAIL branch_len1: got %b exp 0", fif1);
                n_errors++;
            end
            if (i == 1) n_checks++;
        end
        step();
        if ({fif0, ff0} !== 2'b01) begin
            $display("FAIL branch_end: got %b exp 01", {fif0, ff0});
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; mem_ready = 1;
        #1;
        if (fa0 !== 1'b0) begin
            $display("FAIL zero_wait_freeze: got %b exp 0", fa0);
            n_errors++;
        end
        n_checks++;
        step();
        if (mw0 !== 1'b0) begin
            $display("FAIL zero_wait_state: got %b exp 0", mw0);
            n_errors++;
        end
        n_checks++;
        mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            if (i >= 2) branch_taken = 1;
            #1;
            if ({fa0, mw0, fif0, fie0, ff0} !== {1'b1, (i != 0), 3'b000}) begin
                $display("FAIL mem_wait_cyc%0d: got %b exp %b", i, {fa0, mw0, fif0, fie0, ff0}, {1'b1, (i != 0), 3'b000});
                n_errors++;
            end
            n_checks++;
            step();
        end
        mem_ready = 1;
        #1;
        if ({fa0, mw0, fif0, fie0} !== 4'b0111) begin
            $display("FAIL mem_ready_cyc: got %b exp 0111", {fa0, mw0, fif0, fie0});
            n_errors++;
        end
        n_checks++;
        if (sc0 !== 16'd4) begin
            $display("FAIL mem_stall_cnt: got %0d exp 4", sc0);
            n_errors++;
        end
        n_checks++;
        step();
        mem_req = 0; mem_ready = 0; branch_taken = 0;
        #1;
        if ({mw0, sc0} !== {1'b0, 16'd4}) begin
            $display("FAIL mem_exit: got mw=%b cnt=%0d exp mw=0 cnt=4", mw0, sc0);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 5; i++) step();
        if (sc1 !== 2'd3) begin
            $display("FAIL stall_cnt_saturate: got %0d exp 3", sc1);
            n_errors++;
        end
        n_checks++;
        if (sc0 !== 16'd5) begin
            $display("FAIL stall_cnt_wide: got %0d exp 5", sc0);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        branch_taken = 1;
        step();
        branch_taken = 0; mem_req = 1; mem_ready = 0;
        step();
        if ({mw0, fif0, sc0} !== {2'b10, 16'd1}) begin
            $display("FAIL pre_abort: got mw=%b fif=%b cnt=%0d exp mw=1 fif=0 cnt=1", mw0, fif0, sc0);
            n_errors++;
        end
        n_checks++;
        #2 rst = 1'b1;
        #1;
        if ({ff0, bub0, fa0, fif0, fie0, fa_a0, fa_b0, mw0, sc0} !== 27'd0) begin
            $display("FAIL async_abort: got %b exp 0", {ff0, bub0, fa0, fif0, fie0, fa_a0, fa_b0, mw0, sc0});
            n_errors++;
        end
        n_checks++;
        clear_inputs();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if ({fif0, mw0} !== 2'b00) begin
                $display("FAIL residual_flush_%0d: got %b exp 00", i, {fif0, mw0});
                n_errors++;
            end
            n_checks++;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #2;
        test_reset();
        test_load_use();
        test_forwarding();
        test_raw_stall();
        test_branch_flush();
        test_mem_wait();
        test_saturation();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Parametrised pipeline control unit for the 5-stage ARM core. It replaces the hard-wired hazard=0, freeze=0, flush=0 and Branch_taken=0 ties in the core top level. It generates stall, flush and forwarding controls from the ID, EXE, MEM and WB stage status. It adds two behaviours the current top level lacks:
- a multi-cycle memory-wait freeze;
- a configurable branch-shadow flush length.
It also keeps a saturating stall counter for performance measurement.

Parameters:
REG_AW, 4, register-address width (number of registers = 2**REG_AW).
FWD_EN, 1, 1 = forwarding mode (only load-use stalls); 0 = stall on any RAW hazard.
BR_FLUSH_CYCLES, 1, cycles IF/ID is flushed after a taken branch; legal range 1..3.
CNT_W, 16, stall-counter width.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
id_src1  in  REG_AW  Rn of the instruction in ID
id_src2  in  REG_AW  Rm/Rd source of the instruction in ID
id_two_src  in  1  ID instruction reads id_src2
id_valid  in  1  ID holds a real instruction (not a bubble)
exe_dest  in  REG_AW  destination of the instruction in EXE
exe_wb_en  in  1  EXE instruction writes back
exe_mem_r_en  in  1  EXE instruction is a load
exe_src1  in  REG_AW  EXE operand-1 register
exe_src2  in  REG_AW  EXE operand-2 register
mem_dest  in  REG_AW  MEM-stage destination
mem_wb_en  in  1  MEM-stage write-back enable
mem_req  in  1  MEM stage is accessing memory
mem_ready  in  1  memory completes the access this cycle
wb_dest  in  REG_AW  WB-stage destination
wb_en  in  1  WB-stage write-back enable
branch_taken  in  1  EXE resolved a taken branch
freeze_front  out  1  hold PC and IF/ID
bubble_id_exe  out  1  insert a NOP into ID/EXE
freeze_all  out  1  hold every pipeline register (memory wait)
flush_if_id  out  1  clear IF/ID
flush_id_exe  out  1  clear ID/EXE
fwd_sel_a  out  2  EXE operand-A source: 00 regfile, 01 MEM, 10 WB
fwd_sel_b  out  2  EXE operand-B source, same encoding
mem_wait  out  1  registered; FSM is in MEM_WAIT
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE; flush counter = 0; stall_cnt = 0; mem_wait = 0.
  - While rst = 1, every combinational output is forced to 0.
- Hazard match, combinational. A source matches only if the writer's enable is set and the register addresses are equal; id_src2 counts only when id_two_src = 1. No hazard is raised when id_valid = 0.
- FWD_EN = 0: hazard = ID source matches (EXE dest & exe_wb_en) or (MEM dest & mem_wb_en). fwd_sel_a and fwd_sel_b are 00.
- FWD_EN = 1: hazard only on load-use, i.e. exe_mem_r_en and an ID source matches exe_dest.
- Forwarding for each EXE operand:
  - MEM match → 01, and MEM has priority over WB;
  - otherwise WB match → 10;
  - otherwise 00.
- A hazard drives freeze_front = 1 and bubble_id_exe = 1 in the same cycle.
- Memory FSM, states IDLE and MEM_WAIT:
  - IDLE → MEM_WAIT when mem_req & !mem_ready.
  - MEM_WAIT → IDLE on the edge where mem_ready = 1.
  - freeze_all = (mem_req & !mem_ready). It is combinational so the first wait cycle is covered.
  - While freeze_all = 1: freeze_front, bubble_id_exe, flush_if_id and flush_id_exe are all 0, and the flush counter holds.
  - mem_req & mem_ready in IDLE is a zero-wait access and produces no freeze.
- Branch handling, when branch_taken = 1 and freeze_all = 0:
  - flush_if_id = 1 and flush_id_exe = 1 in that cycle.
  - The flush counter loads BR_FLUSH_CYCLES-1.
  - While the counter is nonzero, flush_if_id = 1 and the counter decrements each cycle.
  - A new branch_taken reloads the counter.
- Priority, highest first: freeze_all, then branch flush, then hazard stall. When a branch flush is active, freeze_front and bubble_id_exe are 0.
- stall_cnt increments by 1 on each clock edge where freeze_front or freeze_all is 1. It saturates at 2**CNT_W-1 and does not wrap.
- Latency:
  - All control outputs are combinational, with zero cycles from input to output.
  - mem_wait and stall_cnt are registered, with one cycle of latency.
- Reset mid-wait or mid-flush aborts immediately; no flush is pending after reset.

Decomposition:
- Package arm_pkg: fwd-select enum (FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10) and the mem-FSM state enum.
- Sub-module fwd_select: a pure comparator that is instantiated twice, once for operand A and once for operand B.

Test Plan:
1. FWD_EN=1; exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3, id_valid=1 → freeze_front=1, bubble_id_exe=1, and stall_cnt increments 0→1.
2. FWD_EN=1; exe_src1=5, mem_dest=5, mem_wb_en=1, wb_dest=5, wb_en=1 → fwd_sel_a=01. With mem_wb_en=0 instead → fwd_sel_a=10.
3. FWD_EN=0; id_src2=7, id_two_src=1, mem_dest=7, mem_wb_en=1 → stall. The same stimulus with id_two_src=0 → no stall.
4. BR_FLUSH_CYCLES=3; branch_taken for 1 cycle → flush_id_exe high for 1 cycle and flush_if_id high for 3 cycles. A coincident load-use hazard → freeze_front stays 0.
5. mem_req=1 with mem_ready=0 for 4 cycles, then mem_ready=1:
   - freeze_all high for 4 cycles;
   - mem_wait high 1 cycle later than freeze_all, for 4 cycles;
   - stall_cnt advances by 4;
   - a branch_taken during the wait is flushed only after the wait ends.
6. Assert rst asynchronously in MEM_WAIT with the flush counter at 2 → mem_wait=0, stall_cnt=0 and all outputs 0 immediately. After rst falls, no residual flush occurs.
